// File: rtl/tetris_pkg.sv
// Shared definitions for the tetris game sequencer, playfield board and display mux.
package tetris_pkg;
  localparam int DEF_BLOCK_SIZE = 20;
  localparam int DEF_COLS       = 24;
  localparam int DEF_ROWS       = 24;

  localparam logic [2:0] SHAPE_SQ   = 3'd0;
  localparam logic [2:0] SHAPE_HBAR = 3'd1;
  localparam logic [2:0] SHAPE_VBAR = 3'd2;

  typedef enum logic [2:0] {
    ST_SPAWN, ST_IDLE, ST_CHK_MV, ST_CHK_FALL, ST_LOCK, ST_CLEAR, ST_OVER
  } state_t;

  typedef enum logic [1:0] {MV_NONE, MV_LEFT, MV_RIGHT} move_t;

  function automatic int shape_width(input logic [2:0] s);
    case (s)
      SHAPE_SQ:   return 2;
      SHAPE_HBAR: return 4;
      default:    return 1;
    endcase
  endfunction

  function automatic int shape_height(input logic [2:0] s);
    case (s)
      SHAPE_SQ:   return 2;
      SHAPE_HBAR: return 1;
      default:    return 4;
    endcase
  endfunction
endpackage

// File: rtl/tetris_game_ctrl_tick_gen.sv
// Gravity divider: counts 0..GRAVITY_DIV-1 while enabled, one-cycle tick on wrap.
module tick_gen #(
  parameter int GRAVITY_DIV = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic grav_tick
);
  localparam int CW = $clog2(GRAVITY_DIV);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == CW'(GRAVITY_DIV - 1)) ? '0 : count + CW'(1);
    end
  end

  assign grav_tick = enable && (count == CW'(GRAVITY_DIV - 1));
endmodule

// File: rtl/tetris_game_ctrl.sv
// Falling-piece sequencer: spawn, moves, gravity, lock, row clear, score and game-over.
module tetris_game_ctrl #(
  parameter int BLOCK_SIZE  = tetris_pkg::DEF_BLOCK_SIZE,
  parameter int COLS        = tetris_pkg::DEF_COLS,
  parameter int ROWS        = tetris_pkg::DEF_ROWS,
  parameter int SPAWN_COL   = 14,
  parameter int GRAVITY_DIV = 1000000,
  parameter int NUM_SHAPES  = 3
) (
  input  logic        iVGA_CLK,
  input  logic        start_over,
  input  logic        key_left,
  input  logic        key_right,
  output logic        chk_req,
  output logic [4:0]  chk_col,
  output logic [4:0]  chk_row,
  output logic [2:0]  chk_shape,
  input  logic        chk_ack,
  input  logic        chk_hit,
  output logic        lock_req,
  input  logic        lock_ack,
  output logic        clr_req,
  input  logic        clr_ack,
  input  logic [2:0]  clr_rows,
  output logic [9:0]  ref_x,
  output logic [9:0]  ref_y,
  output logic [2:0]  shape,
  output logic        stop,
  output logic [15:0] score,
  output logic        game_over
);
  import tetris_pkg::*;

  state_t      state, state_d;
  move_t       pend_mv, pend_mv_d;
  logic [4:0]  col, col_d, row, row_d;
  logic [2:0]  shape_d, next_shape, next_shape_d;
  logic [15:0] score_d;
  logic        chk_req_d, lock_req_d, clr_req_d, stop_d;
  logic [4:0]  chk_col_d, chk_row_d;
  logic [2:0]  chk_shape_d;
  logic        grav_pend, grav_pend_d, spawned, spawned_d, grav_tick;
  logic        chk_done, lock_done, clr_done;
  logic [16:0] score_sum;

  tick_gen #(.GRAVITY_DIV(GRAVITY_DIV)) u_tick (
    .clk       (iVGA_CLK),
    .rst       (start_over),
    .enable    (state != ST_OVER),
    .grav_tick (grav_tick)
  );

  // Handshake: req is registered and held with a stable payload until ack is
  // sampled high; it drops the following cycle. ack while req is low is ignored.
  assign chk_done  = chk_req & chk_ack;
  assign lock_done = lock_req & lock_ack;
  assign clr_done  = clr_req & clr_ack;
  assign score_sum = {1'b0, score} + 17'(clr_rows);
  assign game_over = (state == ST_OVER);

  always_comb begin
    state_d      = state;
    col_d        = col;
    row_d        = row;
    shape_d      = shape;
    next_shape_d = next_shape;
    score_d      = score;
    chk_req_d    = chk_req;
    chk_col_d    = chk_col;
    chk_row_d    = chk_row;
    chk_shape_d  = chk_shape;
    lock_req_d   = lock_req;
    clr_req_d    = clr_req;
    stop_d       = 1'b0;
    grav_pend_d  = grav_pend | grav_tick;
    pend_mv_d    = pend_mv;
    spawned_d    = spawned;
    case (state)
      ST_SPAWN: begin
        // First cycle loads the new piece and raises the spawn query.
        if (!spawned) begin
          col_d        = 5'(SPAWN_COL);
          row_d        = '0;
          shape_d      = next_shape;
          next_shape_d = (next_shape == 3'(NUM_SHAPES - 1)) ? '0 : next_shape + 3'd1;
          chk_req_d    = 1'b1;
          chk_col_d    = 5'(SPAWN_COL);
          chk_row_d    = '0;
          chk_shape_d  = next_shape;
          spawned_d    = 1'b1;
          grav_pend_d  = 1'b0;
        end else if (chk_done) begin
          chk_req_d = 1'b0;
          spawned_d = 1'b0;
          state_d   = chk_hit ? ST_OVER : ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (pend_mv == MV_LEFT && col == '0) begin
          pend_mv_d = MV_NONE;
        end else if (pend_mv == MV_RIGHT && int'(col) + shape_width(shape) >= COLS) begin
          pend_mv_d = MV_NONE;
        end else if (pend_mv != MV_NONE) begin
          chk_req_d   = 1'b1;
          chk_col_d   = (pend_mv == MV_LEFT) ? col - 5'd1 : col + 5'd1;
          chk_row_d   = row;
          chk_shape_d = shape;
          state_d     = ST_CHK_MV;
        end else if (grav_pend) begin
          if (int'(row) + shape_height(shape) >= ROWS) begin
            lock_req_d  = 1'b1;
            grav_pend_d = grav_tick;
            state_d     = ST_LOCK;
          end else begin
            chk_req_d   = 1'b1;
            chk_col_d   = col;
            chk_row_d   = row + 5'd1;
            chk_shape_d = shape;
            state_d     = ST_CHK_FALL;
          end
        end
      end
      ST_CHK_MV: begin
        if (chk_done) begin
          chk_req_d = 1'b0;
          if (!chk_hit) col_d = chk_col;
          pend_mv_d = MV_NONE;
          state_d   = ST_IDLE;
        end
      end
      ST_CHK_FALL: begin
        if (chk_done) begin
          chk_req_d   = 1'b0;
          grav_pend_d = grav_tick;
          if (chk_hit) begin
            lock_req_d = 1'b1;
            state_d    = ST_LOCK;
          end else begin
            row_d   = row + 5'd1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_LOCK: begin
        if (lock_done) begin
          lock_req_d = 1'b0;
          stop_d     = 1'b1;
          clr_req_d  = 1'b1;
          state_d    = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (clr_done) begin
          clr_req_d   = 1'b0;
          score_d     = score_sum[16] ? 16'hFFFF : score_sum[15:0];
          grav_pend_d = 1'b0;
          state_d     = ST_SPAWN;
        end
      end
      ST_OVER: begin
        grav_pend_d = 1'b0;
      end
      default: state_d = ST_SPAWN;
    endcase
    // Newest key pulse wins; simultaneous left+right cancels out.
    if (state != ST_OVER && (key_left ^ key_right)) begin
      pend_mv_d = key_left ? MV_LEFT : MV_RIGHT;
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (start_over) begin
      state      <= ST_SPAWN;
      col        <= 5'(SPAWN_COL);
      row        <= '0;
      shape      <= SHAPE_SQ;
      next_shape <= SHAPE_HBAR;
      score      <= '0;
      chk_req    <= 1'b0;
      chk_col    <= '0;
      chk_row    <= '0;
      chk_shape  <= '0;
      lock_req   <= 1'b0;
      clr_req    <= 1'b0;
      stop       <= 1'b0;
      grav_pend  <= 1'b0;
      pend_mv    <= MV_NONE;
      spawned    <= 1'b0;
      ref_x      <= 10'(SPAWN_COL * BLOCK_SIZE);
      ref_y      <= '0;
    end else begin
      state      <= state_d;
      col        <= col_d;
      row        <= row_d;
      shape      <= shape_d;
      next_shape <= next_shape_d;
      score      <= score_d;
      chk_req    <= chk_req_d;
      chk_col    <= chk_col_d;
      chk_row    <= chk_row_d;
      chk_shape  <= chk_shape_d;
      lock_req   <= lock_req_d;
      clr_req    <= clr_req_d;
      stop       <= stop_d;
      grav_pend  <= grav_pend_d;
      pend_mv    <= pend_mv_d;
      spawned    <= spawned_d;
      ref_x      <= 10'(int'(col) * BLOCK_SIZE);
      ref_y      <= 10'(int'(row) * BLOCK_SIZE);
    end
  end
endmodule

// File: doc/tetris_game_ctrl.md
Name: tetris_game_ctrl

Overview:
Game sequencer for the tetris playfield. Owns the falling piece: position in cell units, shape, gravity timing, left/right moves, spawn, lock, row-clear scheduling, score and game-over. Does not store the board; collision queries and board writes go over req/ack handshakes to the playfield/board unit. Exports ref_x/ref_y in pixels and shape, for use by the display mux.

Parameters:
BLOCK_SIZE, 20, pixels per cell edge
COLS, 24, playfield width in cells
ROWS, 24, playfield height in cells
SPAWN_COL, 14, spawn column (pixel x 280)
GRAVITY_DIV, 1000000, clock cycles per gravity step (>=2)
NUM_SHAPES, 3, shapes in rotation (0 square 2x2, 1 horizontal 4x1, 2 vertical 1x4)

Ports:
iVGA_CLK  in  1  sole clock
start_over  in  1  synchronous active-high reset; also restarts the game
key_left  in  1  one-cycle move-left pulse
key_right  in  1  one-cycle move-right pulse
chk_req  out  1  collision query request
chk_col  out  5  query column (cell units)
chk_row  out  5  query row
chk_shape  out  3  query shape
chk_ack  in  1  query done
chk_hit  in  1  query result; valid only when chk_ack=1
lock_req  out  1  write the current piece into the board
lock_ack  in  1  write done
clr_req  out  1  scan the board and clear full rows
clr_ack  in  1  scan done
clr_rows  in  3  rows cleared; valid when clr_ack=1
ref_x  out  10  piece x in pixels = col*BLOCK_SIZE
ref_y  out  10  piece y in pixels = row*BLOCK_SIZE
shape  out  3  current shape
stop  out  1  one-cycle pulse when a piece locks
score  out  16  total cleared rows
game_over  out  1  level, high while in OVER

Behaviour:
- Clock and reset: one clock, iVGA_CLK. start_over is a synchronous, active-high reset. Reset takes priority over everything, including in-flight handshakes. Reset values: state=SPAWN, col=SPAWN_COL, row=0, shape=0, next_shape=1, score=0, all req outputs=0, stop=0, game_over=0, gravity counter=0, pending move cleared.
- Gravity: counter counts 0..GRAVITY_DIV-1 and pulses grav_tick on wrap. The tick is latched in grav_pend until consumed. The counter runs in every state except OVER.
- Move latch: pend_mv takes values {none, left, right}. A new pulse overwrites the old one (newest wins). If key_left and key_right arrive together, both are ignored.
- Handshake rules, for all three channels:
  - req rises only from IDLE or a sequencing state.
  - req stays high, with payload stable, until the cycle ack=1 is sampled.
  - req drops on the cycle after ack.
  - ack asserted while req is low is ignored.
  - Minimum latency is req to ack in 1 cycle.
- FSM states: SPAWN, IDLE, CHK_MV, CHK_FALL, LOCK, CLEAR, OVER.
  - SPAWN: load col=SPAWN_COL, row=0, shape=next_shape; next_shape=(next_shape+1) mod NUM_SHAPES. Issue chk at the spawn position. If hit, go to OVER; else go to IDLE.
  - IDLE:
    - A pending move has priority over gravity.
    - Left with col=0 is discarded without a query.
    - Right with col+width(shape)>=COLS is discarded without a query.
    - Otherwise go to CHK_MV with target col±1.
    - Else, if grav_pend is set: when row+height(shape)>=ROWS, go directly to LOCK (no query); otherwise go to CHK_FALL with target row+1.
  - CHK_MV: on ack with hit=0, commit col; on hit=1, no change. Clear pend_mv (unless a new pulse arrived in the same cycle), then return to IDLE.
  - CHK_FALL: on ack with hit=0, row+=1 and go to IDLE; on hit=1, go to LOCK. Clear grav_pend either way.
  - LOCK: assert lock_req. On ack, pulse stop for exactly one cycle and go to CLEAR.
  - CLEAR: assert clr_req. On ack, score+=clr_rows, saturating at 16'hFFFF, then go to SPAWN.
  - OVER: game_over=1, all reqs low, inputs ignored. Exit only via start_over.
- ref_x and ref_y are registered and follow col/row with 1-cycle latency. Multiply by BLOCK_SIZE; the result fits in 10 bits for the defaults.
- Key pulses arriving during LOCK, CLEAR or SPAWN are latched and handled in the next IDLE. grav_pend is cleared on entry to SPAWN, so a fresh piece does not drop immediately.
- start_over mid-handshake: req drops the next cycle; the board unit must tolerate an abandoned transaction.

Decomposition:
- tetris_pkg holds:
  - state enum/localparams
  - shape codes SHAPE_SQ=0, SHAPE_HBAR=1, SHAPE_VBAR=2
  - functions shape_width(): 2,4,1
  - functions shape_height(): 2,1,4
  - default BLOCK_SIZE, COLS and ROWS, shared with the display and board units
- One sub-module, tick_gen (GRAVITY_DIV, enable, grav_tick), for the gravity divider.

Test Plan:
- Reset, then a chk_ack/hit=0 responder: spawns shape 1 at col 14/row 0 (ref_x=280, ref_y=0). After GRAVITY_DIV cycles plus the handshake, ref_y=20.
- key_left at col 0: no chk_req issued and col stays 0. key_right with shape 1 at col 20: discarded (20+4>=24).
- Bench answers CHK_FALL with hit=1: exactly one lock_req, stop high one cycle, then clr_req. clr_rows=2 gives score=2, then SPAWN with the next shape.
- Vertical bar (shape 2) falls to row 20: locks without a chk_req, because 20+4>=24.
- Spawn query answered hit=1: game_over=1, no further reqs for 1000 cycles; start_over clears score and state.
- Hold chk_ack low 50 cycles: chk_req and payload stay stable. Pulse start_over mid-wait: chk_req low the next cycle and all outputs at reset values.
